// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry, tile encoding and palette for the snake renderer
package snake_pkg;
    localparam int TILE_LOG2 = 4;
    localparam int GRID_W    = 40;
    localparam int GRID_H    = 30;
    localparam int GRID_N    = GRID_W * GRID_H;
    localparam int VIS_W     = 640;
    localparam int VIS_H     = 480;
    localparam int ADDR_W    = 11;

    localparam logic [11:0] COL_BG   = 12'h000;
    localparam logic [11:0] COL_BODY = 12'h0F0;
    localparam logic [11:0] COL_HEAD = 12'hFF0;
    localparam logic [11:0] COL_FOOD = 12'hF00;
    localparam logic [11:0] COL_EDGE = 12'h333;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_BODY  = 2'd1,
        TILE_HEAD  = 2'd2,
        TILE_FOOD  = 2'd3
    } tile_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // y*40 + x without a multiplier
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] y, input logic [5:0] x);
        return ({6'd0, y} << 5) + ({6'd0, y} << 3) + {5'd0, x};
    endfunction
endpackage

// File: rtl/tile_ram_dp.sv
// tile_ram_dp: 1200x2 simple dual-port tile RAM, synchronous read returning old data on collision
module tile_ram_dp
    import snake_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data
);
    logic [1:0] mem_q [GRID_N];
    logic [1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: tile-grid playfield with a 2-cycle pixel pipeline and a clear-sweep FSM
module snake_tile_renderer
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        RSTN,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        rdn,
    output logic [11:0] pixel_data,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [1:0]  wr_type,
    output logic        wr_ready,
    input  logic        clr_req,
    output logic        clr_busy
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              clr_busy_q, clr_busy_d;
    logic              wr_ready_q, wr_ready_d;
    logic              s1_vis_q;
    logic [3:0]        s1_roff_q, s1_coff_q;
    logic [11:0]       pixel_data_q, pixel_data_d;
    logic              vis, wr_ok, on_edge, ram_wr_en;
    logic [ADDR_W-1:0] rd_addr, ram_wr_addr;
    logic [1:0]        rd_data, ram_wr_data;
    tile_t             s1_tile;

    // Off-screen coordinates read address 0 so they never alias into the grid
    always_comb begin
        vis     = !rdn && (row < 9'(VIS_H)) && (col < 10'(VIS_W));
        rd_addr = vis ? tile_addr(row[8:TILE_LOG2], col[9:TILE_LOG2]) : '0;
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        clr_busy_d = clr_busy_q;
        wr_ready_d = wr_ready_q;
        wr_ok      = 1'b0;
        if (clr_req) begin
            state_d    = ST_CLEAR;
            sweep_d    = '0;
            clr_busy_d = 1'b1;
            wr_ready_d = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == ADDR_W'(GRID_N - 1)) begin
                state_d    = ST_IDLE;
                sweep_d    = '0;
                clr_busy_d = 1'b0;
                wr_ready_d = 1'b1;
            end
        end else begin
            wr_ok = wr_en && (wr_x < 6'(GRID_W)) && (wr_y < 5'(GRID_H));
        end
        ram_wr_en   = (state_q == ST_CLEAR) || wr_ok;
        ram_wr_addr = (state_q == ST_CLEAR) ? sweep_q : tile_addr(wr_y, wr_x);
        ram_wr_data = (state_q == ST_CLEAR) ? TILE_EMPTY : wr_type;
    end

    tile_ram_dp u_ram (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    always_comb begin
        s1_tile      = tile_t'(rd_data);
        on_edge      = (s1_roff_q == 4'h0) || (s1_roff_q == 4'hF) ||
                       (s1_coff_q == 4'h0) || (s1_coff_q == 4'hF);
        pixel_data_d = !s1_vis_q                ? 12'h000  :
                       (s1_tile == TILE_EMPTY)  ? COL_BG   :
                       on_edge                  ? COL_EDGE :
                       (s1_tile == TILE_BODY)   ? COL_BODY :
                       (s1_tile == TILE_HEAD)   ? COL_HEAD : COL_FOOD;
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_CLEAR;
            sweep_q      <= '0;
            clr_busy_q   <= 1'b1;
            wr_ready_q   <= 1'b0;
            s1_vis_q     <= 1'b0;
            s1_roff_q    <= '0;
            s1_coff_q    <= '0;
            pixel_data_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            clr_busy_q   <= clr_busy_d;
            wr_ready_q   <= wr_ready_d;
            s1_vis_q     <= vis;
            s1_roff_q    <= row[TILE_LOG2-1:0];
            s1_coff_q    <= col[TILE_LOG2-1:0];
            pixel_data_q <= pixel_data_d;
        end
    end

    assign pixel_data = pixel_data_q;
    assign wr_ready   = wr_ready_q;
    assign clr_busy   = clr_busy_q;
endmodule

// File: tb/tb_snake_tile_renderer.sv
// tb_snake_tile_renderer: scoreboard bench for the snake tile renderer
module tb_snake_tile_renderer;
    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic [8:0]  row = '0;
    logic [9:0]  col = '0;
    logic        rdn = 1'b1;
    logic [11:0] pixel_data;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_x = '0;
    logic [4:0]  wr_y = '0;
    logic [1:0]  wr_type = '0;
    logic        wr_ready;
    logic        clr_req = 1'b0;
    logic        clr_busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_req = 1'b0, p1 = 1'b0, p2 = 1'b0;

    typedef struct {
        logic [11:0] want;
        int          r;
        int          c;
        string       name;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    logic [1:0] model [30][40];

    always #5 clk = ~clk;

    snake_tile_renderer dut (
        .clk        (clk),
        .RSTN       (RSTN),
        .row        (row),
        .col        (col),
        .rdn        (rdn),
        .pixel_data (pixel_data),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_type    (wr_type),
        .wr_ready   (wr_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy)
    );

    // Read tags follow the DUT's two-stage latency, then the monitor checks
    always @(posedge clk) begin
        p2 <= p1;
        p1 <= chk_req;
    end

    always @(negedge clk) begin
        if (p2) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow got=%h with no expected entry", pixel_data);
            end else begin
                cur = sb.pop_front();
                if (pixel_data !== cur.want) begin
                    n_fail++;
                    $display("FAIL %s row=%0d col=%0d got=%h expected=%h",
                             cur.name, cur.r, cur.c, pixel_data, cur.want);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    function automatic logic [11:0] exp_px(input int r, input int c, input bit n);
        logic [1:0] t;
        int ro, co;
        if (n || r >= 480 || c >= 640) return 12'h000;
        t  = model[r / 16][c / 16];
        ro = r % 16;
        co = c % 16;
        if (t == 2'd0) return 12'h000;
        if (ro == 0 || ro == 15 || co == 0 || co == 15) return 12'h333;
        return (t == 2'd1) ? 12'h0F0 : (t == 2'd2) ? 12'hFF0 : 12'hF00;
    endfunction

    task automatic rd(input int r, input int c, input bit n, input logic [11:0] want, input string name);
        @(posedge clk); #1;
        row = 9'(r);
        col = 10'(c);
        rdn = n;
        chk_req = 1'b1;
        sb.push_back('{want: want, r: r, c: c, name: name});
    endtask

    task automatic drain();
        @(posedge clk); #1;
        chk_req = 1'b0;
        rdn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input int t);
        @(posedge clk); #1;
        chk_req = 1'b0;
        wr_en = 1'b1;
        wr_x = 6'(x);
        wr_y = 5'(y);
        wr_type = 2'(t);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (clr_busy && n < 1300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic clear_model();
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++)
                model[y][x] = 2'd0;
    endtask

    task automatic scan();
        int r, c;
        for (int y = 0; y < 30; y++)
            for (int x = 0; x < 40; x++) begin
                r = y * 16 + (x * 7 + y * 3) % 16;
                c = x * 16 + (x * 5 + y) % 16;
                rd(r, c, 1'b0, exp_px(r, c, 1'b0), "scan");
            end
        drain();
    endtask

    initial begin
        int n;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel", pixel_data, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_clr_busy", clr_busy, 1);
        RSTN = 1'b1;
        wait_idle(n);
        chk("sweep_len_reset", n, 1200);
        chk("ready_after_sweep", wr_ready, 1);
        chk("busy_after_sweep", clr_busy, 0);
        scan();

        wr(3, 2, 2);
        model[2][3] = 2'd2;
        rd(37, 53, 1'b0, 12'hFF0, "head_center");
        rd(32, 48, 1'b0, 12'h333, "head_edge_tl");
        rd(47, 63, 1'b0, 12'h333, "head_edge_br");
        rd(40, 49, 1'b0, 12'hFF0, "head_inner");
        drain();

        wr(39, 29, 3);
        model[29][39] = 2'd3;
        rd(479, 639, 1'b0, 12'h333, "food_corner");
        rd(470, 630, 1'b0, 12'hF00, "food_center");
        rd(470, 640, 1'b0, 12'h000, "col_640");
        rd(470, 630, 1'b1, 12'h000, "rdn_high");
        rd(480, 630, 1'b0, 12'h000, "row_480");
        rd(511, 1023, 1'b0, 12'h000, "max_coords");
        drain();

        wr(40, 0, 1);
        wr(0, 30, 2);
        wr(63, 31, 3);
        scan();

        wr(5, 5, 1);
        model[5][5] = 2'd1;
        rd(88, 88, 1'b0, 12'h0F0, "body_55");
        drain();

        @(posedge clk); #1;
        clr_req = 1'b1;
        wr_en = 1'b1;
        wr_x = 6'd6;
        wr_y = 5'd6;
        wr_type = 2'd2;
        @(posedge clk); #1;
        clr_req = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_clr", clr_busy, 1);
        chk("ready_low_clr", wr_ready, 0);
        rd(104, 104, 1'b0, 12'h000, "clr_drops_write");
        rd(88, 88, 1'b0, 12'h0F0, "partial_clear_old");
        drain();
        wr(20, 20, 1);
        rd(328, 328, 1'b0, 12'h000, "busy_write_ignored");
        drain();
        wait_idle(n);
        chk("clear_finished", clr_busy, 0);
        clear_model();
        rd(88, 88, 1'b0, 12'h000, "body_cleared");
        rd(37, 53, 1'b0, 12'h000, "head_cleared");
        drain();

        pulse_clr();
        repeat (100) @(posedge clk);
        #1;
        chk("busy_mid_sweep", clr_busy, 1);
        pulse_clr();
        wait_idle(n);
        chk("sweep_len_restart", n, 1200);

        wr(39, 29, 3);
        model[29][39] = 2'd3;
        pulse_clr();
        row = 9'd470;
        col = 10'd630;
        rdn = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        chk("pixel_pre_reset", pixel_data, 12'hF00);
        #2;
        RSTN = 1'b0;
        #1;
        chk("async_rst_pixel", pixel_data, 0);
        chk("async_rst_busy", clr_busy, 1);
        chk("async_rst_ready", wr_ready, 0);
        rdn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RSTN = 1'b1;
        wait_idle(n);
        chk("sweep_len_after_reset", n, 1200);
        clear_model();
        scan();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
